// File: rtl/ccip_mem_resp_pkg.sv
// Shared types for the CCI-P memory responder: line/tag/index types, the queued write
// request record, and the byte-enable helper used by partial-line writes.
package ccip_mem_resp_pkg;

    localparam int LINE_W     = 512;
    localparam int ADDR_W     = 42;
    localparam int MDATA_W    = 16;
    localparam int MEM_LINES  = 256;
    localparam int IDX_W      = $clog2(MEM_LINES);
    localparam int LINE_BYTES = LINE_W / 8;

    typedef logic [LINE_W-1:0]     t_line;
    typedef logic [MDATA_W-1:0]    t_mdata;
    typedef logic [IDX_W-1:0]      t_line_idx;
    typedef logic [LINE_BYTES-1:0] t_byte_en;

    typedef struct packed {
        t_line_idx  idx;
        t_mdata     mdata;
        t_line      data;
        logic       byte_mode;
        logic [5:0] byte_start;
        logic [5:0] byte_len;
    } t_wr_req;

    // Bytes in [start, start+len) are enabled; the 7-bit end never wraps and bytes past 63 don't exist.
    function automatic t_byte_en byte_mask(input logic [5:0] start, input logic [5:0] len);
        logic [6:0] stop;
        t_byte_en   m;
        stop = {1'b0, start} + {1'b0, len};
        m    = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            m[i] = (7'(i) >= {1'b0, start}) && (7'(i) < stop);
        end
        return m;
    endfunction

endpackage

// File: rtl/ccip_mem_resp_wq.sv
// Write queue for the memory responder: synchronous FIFO of write requests with occupancy.
// A push while full is only accepted when a pop frees a slot in the same cycle.
module ccip_mem_resp_wq
    import ccip_mem_resp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  t_wr_req                push_req,
    input  logic                   pop,
    output t_wr_req                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    t_wr_req          wq_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && do_push) begin
            wq_mem[wr_ptr_q] <= push_req;
        end
    end

    assign head  = wq_mem[rd_ptr_q];
    assign count = cnt_q;
    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/ccip_mem_responder.sv
// CCI-P host-memory stand-in: c0 line reads and c1 writes against an on-chip line RAM.
// Define CCIP_MEM_RESP_BYTE_MODE_EN to honour byte-mode partial-line writes.
module ccip_mem_responder
    import ccip_mem_resp_pkg::*;
#(
    parameter int RD_LAT         = 4,
    parameter int WQ_DEPTH       = 8,
    parameter int ALMFULL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               c0_req_valid,
    input  logic [ADDR_W-1:0]  c0_req_addr,
    input  logic [MDATA_W-1:0] c0_req_mdata,
    output logic               c0_rsp_valid,
    output logic [MDATA_W-1:0] c0_rsp_mdata,
    output logic [LINE_W-1:0]  c0_rsp_data,
    input  logic               c1_req_valid,
    input  logic [ADDR_W-1:0]  c1_req_addr,
    input  logic [MDATA_W-1:0] c1_req_mdata,
    input  logic               c1_req_byte_mode,
    input  logic [5:0]         c1_req_byte_start,
    input  logic [5:0]         c1_req_byte_len,
    input  logic [LINE_W-1:0]  c1_req_data,
    output logic               c1_rsp_valid,
    output logic [MDATA_W-1:0] c1_rsp_mdata,
    output logic               alm_full,
    output logic               overflow
);

    localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

    t_line             line_ram [MEM_LINES];
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    t_mdata            pipe_md_q   [RD_LAT];
    t_mdata            pipe_md_d   [RD_LAT];
    t_line             pipe_data_q [RD_LAT];
    t_line             pipe_data_d [RD_LAT];
    logic              c1_rsp_valid_q, c1_rsp_valid_d;
    t_mdata            c1_rsp_mdata_q, c1_rsp_mdata_d;
    logic              alm_full_q, alm_full_d;
    logic              overflow_q, overflow_d;

    t_wr_req           wq_push_req;
    t_wr_req           wq_head;
    logic [CNT_W-1:0]  wq_count;
    logic              wq_full, wq_empty;
    logic              wr_commit;
    t_byte_en          wr_be;
    logic              unused_addr_hi;

    // Only the low address bits index the RAM; higher line-address bits alias.
    assign unused_addr_hi = ^{c0_req_addr[ADDR_W-1:IDX_W], c1_req_addr[ADDR_W-1:IDX_W]};

    always_comb begin
        wq_push_req            = '0;
        wq_push_req.idx        = c1_req_addr[IDX_W-1:0];
        wq_push_req.mdata      = c1_req_mdata;
        wq_push_req.data       = c1_req_data;
        wq_push_req.byte_mode  = c1_req_byte_mode;
        wq_push_req.byte_start = c1_req_byte_start;
        wq_push_req.byte_len   = c1_req_byte_len;
    end

    ccip_mem_resp_wq #(
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (c1_req_valid),
        .push_req (wq_push_req),
        .pop      (wr_commit),
        .head     (wq_head),
        .count    (wq_count),
        .full     (wq_full),
        .empty    (wq_empty)
    );

    // Reads own the single RAM port; the queue head commits only in read-free cycles.
    always_comb begin
        wr_commit = reset_n && !c0_req_valid && !wq_empty;
`ifdef CCIP_MEM_RESP_BYTE_MODE_EN
        wr_be = wq_head.byte_mode ? byte_mask(wq_head.byte_start, wq_head.byte_len) : '1;
`else
        wr_be = '1;
`endif
        c1_rsp_valid_d = wr_commit;
        c1_rsp_mdata_d = wr_commit ? wq_head.mdata : c1_rsp_mdata_q;
        alm_full_d     = int'(wq_count) >= (WQ_DEPTH - ALMFULL_MARGIN);
        overflow_d     = overflow_q | (c1_req_valid && wq_full && !wr_commit);
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = c0_req_valid;
        pipe_md_d[0]   = c0_req_mdata;
        pipe_data_d[0] = line_ram[c0_req_addr[IDX_W-1:0]];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_md_d[i]   = pipe_md_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_md_q[i]   <= '0;
                pipe_data_q[i] <= '0;
            end
            c1_rsp_valid_q <= 1'b0;
            c1_rsp_mdata_q <= '0;
            alm_full_q     <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            pipe_vld_q     <= pipe_vld_d;
            pipe_md_q      <= pipe_md_d;
            pipe_data_q    <= pipe_data_d;
            c1_rsp_valid_q <= c1_rsp_valid_d;
            c1_rsp_mdata_q <= c1_rsp_mdata_d;
            alm_full_q     <= alm_full_d;
            overflow_q     <= overflow_d;
        end
    end

    // RAM contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (wr_be[b]) begin
                    line_ram[wq_head.idx][8*b +: 8] <= wq_head.data[8*b +: 8];
                end
            end
        end
    end

    assign c0_rsp_valid = pipe_vld_q[RD_LAT-1];
    assign c0_rsp_mdata = pipe_md_q[RD_LAT-1];
    assign c0_rsp_data  = pipe_data_q[RD_LAT-1];
    assign c1_rsp_valid = c1_rsp_valid_q;
    assign c1_rsp_mdata = c1_rsp_mdata_q;
    assign alm_full     = alm_full_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ccip_mem_responder.sv
// Self-checking bench for ccip_mem_responder: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based model of the responder.
module tb_ccip_mem_responder;

    localparam int RD_LAT   = 4;
    localparam int WQ_DEPTH = 8;
    localparam int ALM_AT   = 6;
    localparam int N_LINES  = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         c1_req_valid;
    logic [41:0]  c1_req_addr;
    logic [15:0]  c1_req_mdata;
    logic         c1_req_byte_mode;
    logic [5:0]   c1_req_byte_start;
    logic [5:0]   c1_req_byte_len;
    logic [511:0] c1_req_data;
    logic         c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic         alm_full;
    logic         overflow;

    always #5 clk = ~clk;

    ccip_mem_responder dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .c0_req_valid      (c0_req_valid),
        .c0_req_addr       (c0_req_addr),
        .c0_req_mdata      (c0_req_mdata),
        .c0_rsp_valid      (c0_rsp_valid),
        .c0_rsp_mdata      (c0_rsp_mdata),
        .c0_rsp_data       (c0_rsp_data),
        .c1_req_valid      (c1_req_valid),
        .c1_req_addr       (c1_req_addr),
        .c1_req_mdata      (c1_req_mdata),
        .c1_req_byte_mode  (c1_req_byte_mode),
        .c1_req_byte_start (c1_req_byte_start),
        .c1_req_byte_len   (c1_req_byte_len),
        .c1_req_data       (c1_req_data),
        .c1_rsp_valid      (c1_rsp_valid),
        .c1_rsp_mdata      (c1_rsp_mdata),
        .alm_full          (alm_full),
        .overflow          (overflow)
    );

    typedef struct {
        int           due;
        logic [15:0]  md;
        logic [511:0] data;
    } rsp_t;

    typedef struct {
        int           idx;
        logic [15:0]  md;
        logic [511:0] data;
        bit           bm;
        int           bs;
        int           bl;
    } wreq_t;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    rsp_t         exp_rd[$];
    rsp_t         exp_wr[$];
    wreq_t        wq_m[$];
    logic [511:0] mem_m [N_LINES];
    bit           exp_alm = 0;
    bit           exp_ovf = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [41:0] mk_addr(input int idx);
        logic [33:0] hi;
        hi = {2'($urandom_range(3)), $urandom};
        return {hi, 8'(idx)};
    endfunction

    // A committed write changes bytes of the model line per the byte-mode rule.
    task automatic apply_write(input wreq_t e);
        bit en;
        for (int b = 0; b < 64; b++) begin
            en = 1;
`ifdef CCIP_MEM_RESP_BYTE_MODE_EN
            if (e.bm) en = (b >= e.bs) && (b < e.bs + e.bl);
`endif
            if (en) mem_m[e.idx][8*b +: 8] = e.data[8*b +: 8];
        end
    endtask

    task automatic check_outputs();
        rsp_t r;
        if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
            r = exp_rd.pop_front();
            chk("c0_rsp_valid", 512'(c0_rsp_valid), 512'(1));
            chk("c0_rsp_mdata", 512'(c0_rsp_mdata), 512'(r.md));
            chk("c0_rsp_data", c0_rsp_data, r.data);
        end else begin
            chk("c0_rsp_valid_idle", 512'(c0_rsp_valid), 512'(0));
        end
        if (exp_wr.size() > 0 && exp_wr[0].due == cyc) begin
            r = exp_wr.pop_front();
            chk("c1_rsp_valid", 512'(c1_rsp_valid), 512'(1));
            chk("c1_rsp_mdata", 512'(c1_rsp_mdata), 512'(r.md));
        end else begin
            chk("c1_rsp_valid_idle", 512'(c1_rsp_valid), 512'(0));
        end
        chk("alm_full", 512'(alm_full), 512'(exp_alm));
        chk("overflow", 512'(overflow), 512'(exp_ovf));
    endtask

    task automatic do_cycle(input bit rd, input int ridx, input logic [15:0] rmd,
                            input bit wr, input int widx, input logic [15:0] wmd,
                            input logic [511:0] wdata, input bit bm, input int bs, input int bl);
        int    occ;
        bit    pop;
        bit    drop;
        wreq_t e;
        check_outputs();
        c0_req_valid      = rd;
        c0_req_addr       = mk_addr(ridx);
        c0_req_mdata      = rmd;
        c1_req_valid      = wr;
        c1_req_addr       = mk_addr(widx);
        c1_req_mdata      = wmd;
        c1_req_data       = wdata;
        c1_req_byte_mode  = bm;
        c1_req_byte_start = 6'(bs);
        c1_req_byte_len   = 6'(bl);
        occ  = wq_m.size();
        pop  = !rd && occ > 0;
        drop = 0;
        if (rd) exp_rd.push_back('{cyc + RD_LAT, rmd, mem_m[ridx]});
        if (pop) begin
            e = wq_m.pop_front();
            apply_write(e);
            exp_wr.push_back('{cyc + 1, e.md, '0});
        end
        if (wr) begin
            if (occ == WQ_DEPTH && !pop) drop = 1;
            else wq_m.push_back('{widx, wmd, wdata, bm, bs, bl});
        end
        @(posedge clk);
        #1;
        cyc++;
        c0_req_valid = 0;
        c1_req_valid = 0;
        exp_alm = (occ >= ALM_AT);
        exp_ovf = exp_ovf | drop;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic rd_line(input int idx, input logic [15:0] md);
        do_cycle(1, idx, md, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic wr_line(input int idx, input logic [15:0] md, input logic [511:0] d);
        do_cycle(0, 0, 0, 1, idx, md, d, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_rd.size() + exp_wr.size() + wq_m.size()) > 0; i++) idle(1);
        idle(2);
        chk("drain_rd", 512'(exp_rd.size()), 512'(0));
        chk("drain_wr", 512'(exp_wr.size() + wq_m.size()), 512'(0));
    endtask

    task automatic do_reset();
        check_outputs();
        reset_n      = 0;
        c0_req_valid = 0;
        c1_req_valid = 0;
        exp_rd.delete();
        exp_wr.delete();
        wq_m.delete();
        @(posedge clk);
        #1;
        cyc++;
        reset_n = 1;
        exp_alm = 0;
        exp_ovf = 0;
        chk("rst_c0_data", c0_rsp_data, '0);
        chk("rst_c0_mdata", 512'(c0_rsp_mdata), 512'(0));
        chk("rst_c1_mdata", 512'(c1_rsp_mdata), 512'(0));
    endtask

    task automatic rand_cycles(input int n);
        bit rd, wr, bm;
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(9) < 4);
            wr = ($urandom_range(9) < 4);
            bm = $urandom_range(1) == 1;
            do_cycle(rd, $urandom_range(N_LINES - 1), 16'($urandom),
                     wr, $urandom_range(N_LINES - 1), 16'($urandom), rand_line(),
                     bm, $urandom_range(63), ($urandom_range(7) == 0) ? 0 : $urandom_range(63));
        end
    endtask

    initial begin
        reset_n           = 0;
        c0_req_valid      = 0;
        c0_req_addr       = '0;
        c0_req_mdata      = '0;
        c1_req_valid      = 0;
        c1_req_addr       = '0;
        c1_req_mdata      = '0;
        c1_req_byte_mode  = 0;
        c1_req_byte_start = '0;
        c1_req_byte_len   = '0;
        c1_req_data       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1;
        chk("reset_c0_valid", 512'(c0_rsp_valid), 512'(0));
        chk("reset_c1_valid", 512'(c1_rsp_valid), 512'(0));
        chk("reset_alm_full", 512'(alm_full), 512'(0));
        chk("reset_overflow", 512'(overflow), 512'(0));
        chk("reset_c0_data", c0_rsp_data, '0);

        // Give every line the bench touches a known value.
        for (int i = 0; i < N_LINES; i++) begin
            mem_m[i] = 'x;
            wr_line(i, 16'(16'h100 + i), rand_line());
        end
        drain();

        // Single write then read-back.
        wr_line(5, 16'h0011, {64{8'hA5}});
        idle(3);
        rd_line(5, 16'h0022);
        drain();

        // Read burst starves three queued writes.
        for (int i = 0; i < 3; i++)
            do_cycle(1, i, 16'(16'h200 + i), 1, 8 + i, 16'(16'h300 + i), rand_line(), 0, 0, 0);
        for (int i = 0; i < 17; i++) rd_line($urandom_range(N_LINES - 1), 16'(16'h400 + i));
        drain();

        // Byte-mode write near the end of a zeroed line, plus an empty byte write.
        wr_line(7, 16'h0500, '0);
        drain();
        do_cycle(0, 0, 0, 1, 7, 16'h0501, {64{8'hFF}}, 1, 60, 8);
        do_cycle(0, 0, 0, 1, 6, 16'h0502, {64{8'h3C}}, 1, 10, 0);
        drain();
        rd_line(7, 16'h0503);
        rd_line(6, 16'h0504);
        drain();

        // Read racing a queued write to the same line.
        do_cycle(1, 3, 16'h0600, 1, 3, 16'h0601, rand_line(), 0, 0, 0);
        idle(1);
        rd_line(3, 16'h0602);
        drain();

        rand_cycles(300);
        drain();

        // Fill the write queue under a read stream; the ninth write overflows.
        for (int i = 0; i < 9; i++)
            do_cycle(1, i, 16'(16'h700 + i), 1, i, 16'(16'h800 + i), rand_line(), 0, 0, 0);
        rd_line(1, 16'h0709);
        drain();

        // Reset with reads in flight and writes queued; queued writes must never land.
        for (int i = 0; i < 3; i++)
            do_cycle(1, i, 16'(16'h900 + i), 1, 9 + i, 16'(16'hA00 + i), rand_line(), 0, 0, 0);
        do_reset();
        idle(8);
        for (int i = 0; i < 3; i++) rd_line(9 + i, 16'(16'hB00 + i));
        rand_cycles(60);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
